// File: rtl/dispatch_queue.sv
// dispatch_queue: decode->schedule FIFO driving slot 0 of the MAIN_*/COP_* buses, NOP bubble when empty.
// Define DISPATCH_BYPASS_EN to present an empty-queue instruction the same cycle it arrives.
module dispatch_queue #(
    parameter int unsigned COP_NUMS = 32'd1,
    parameter int unsigned PNUMS    = COP_NUMS + 1,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FLUSH,
    input  logic                  STALL,
    input  logic                  MMU_WAIT,
    input  logic                  DECODE_VALID,
    output logic                  DECODE_READY,
    input  logic [31:0]           DECODE_PC,
    input  logic [16:0]           DECODE_OPCODE,
    input  logic [4:0]            DECODE_RD,
    input  logic [4:0]            DECODE_RS1,
    input  logic [4:0]            DECODE_RS2,
    input  logic [11:0]           DECODE_CSR,
    input  logic [31:0]           DECODE_IMM,
    input  logic                  DECODE_MAIN_HIT,
    input  logic                  DECODE_COP_HIT,
    output logic [PNUMS-1:0]      MAIN_ACCEPT,
    output logic [32*PNUMS-1:0]   MAIN_PC,
    output logic [17*PNUMS-1:0]   MAIN_OPCODE,
    output logic [5*PNUMS-1:0]    MAIN_RD,
    output logic [5*PNUMS-1:0]    MAIN_RS1,
    output logic [5*PNUMS-1:0]    MAIN_RS2,
    output logic [12*PNUMS-1:0]   MAIN_CSR,
    output logic [32*PNUMS-1:0]   MAIN_IMM,
    output logic [PNUMS-1:0]      COP_ACCEPT,
    output logic [32*PNUMS-1:0]   COP_PC,
    output logic [5*PNUMS-1:0]    COP_RD,
    output logic [5*PNUMS-1:0]    COP_RS1,
    output logic [5*PNUMS-1:0]    COP_RS2
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [16:0] NOP_OP = {7'b0010011, 3'b000, 7'b0000000};

    typedef struct packed {
        logic [31:0] pc;
        logic [16:0] opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] csr;
        logic [31:0] imm;
        logic        main_hit;
        logic        cop_hit;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            adv, empty, push, pop, bypass, head_vld;
    entry_t          din, head;

    assign din = {DECODE_PC, DECODE_OPCODE, DECODE_RD, DECODE_RS1, DECODE_RS2,
                  DECODE_CSR, DECODE_IMM, DECODE_MAIN_HIT, DECODE_COP_HIT};

    always_comb begin
        adv          = !STALL && !MMU_WAIT;
        empty        = count_q == '0;
        DECODE_READY = count_q != (AW+1)'(DEPTH);
`ifdef DISPATCH_BYPASS_EN
        bypass       = empty && DECODE_VALID && adv && !FLUSH;
`else
        bypass       = 1'b0;
`endif
        // A bypassed instruction is consumed directly and never occupies an entry.
        push         = DECODE_VALID && DECODE_READY && !FLUSH && !bypass;
        pop          = adv && !empty;
        wr_ptr_d     = FLUSH ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d     = FLUSH ? '0 : rd_ptr_q + AW'(pop);
        count_d      = FLUSH ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
        head_vld     = bypass || !empty;
        head         = bypass ? din : (empty ? '0 : mem_q[rd_ptr_q]);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    always_comb begin
        MAIN_ACCEPT        = '0;
        MAIN_PC            = '0;
        MAIN_OPCODE        = '0;
        MAIN_RD            = '0;
        MAIN_RS1           = '0;
        MAIN_RS2           = '0;
        MAIN_CSR           = '0;
        MAIN_IMM           = '0;
        COP_ACCEPT         = '0;
        COP_PC             = '0;
        COP_RD             = '0;
        COP_RS1            = '0;
        COP_RS2            = '0;
        MAIN_ACCEPT[0]     = head_vld && head.main_hit;
        MAIN_PC[31:0]      = head.pc;
        MAIN_OPCODE[16:0]  = head_vld ? head.opcode : NOP_OP;
        MAIN_RD[4:0]       = head.rd;
        MAIN_RS1[4:0]      = head.rs1;
        MAIN_RS2[4:0]      = head.rs2;
        MAIN_CSR[11:0]     = head.csr;
        MAIN_IMM[31:0]     = head.imm;
        COP_ACCEPT[0]      = head_vld && head.cop_hit;
        COP_PC[31:0]       = head.pc;
        COP_RD[4:0]        = head.rd;
        COP_RS1[4:0]       = head.rs1;
        COP_RS2[4:0]       = head.rs2;
    end
endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue: directed and random stimulus for dispatch_queue checked against a queue model.
module tb_dispatch_queue;
    localparam int DEPTH = 4;
    localparam int PNUMS = 2;
    localparam logic [16:0] NOP_OP = {7'b0010011, 3'b000, 7'b0000000};

    logic CLK = 1'b0;
    logic RST, FLUSH, STALL, MMU_WAIT, DECODE_VALID, DECODE_READY;
    logic [31:0] DECODE_PC, DECODE_IMM;
    logic [16:0] DECODE_OPCODE;
    logic [4:0]  DECODE_RD, DECODE_RS1, DECODE_RS2;
    logic [11:0] DECODE_CSR;
    logic        DECODE_MAIN_HIT, DECODE_COP_HIT;
    logic [PNUMS-1:0]    MAIN_ACCEPT, COP_ACCEPT;
    logic [32*PNUMS-1:0] MAIN_PC, MAIN_IMM, COP_PC;
    logic [17*PNUMS-1:0] MAIN_OPCODE;
    logic [5*PNUMS-1:0]  MAIN_RD, MAIN_RS1, MAIN_RS2, COP_RD, COP_RS1, COP_RS2;
    logic [12*PNUMS-1:0] MAIN_CSR;

    typedef struct packed {
        logic [31:0] pc;
        logic [16:0] op;
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] csr;
        logic [31:0] imm;
        logic        mh, ch;
    } ent_t;

    ent_t q[$];
    int checks = 0;
    int errors = 0;

    dispatch_queue #(.COP_NUMS(1), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .STALL(STALL), .MMU_WAIT(MMU_WAIT),
        .DECODE_VALID(DECODE_VALID), .DECODE_READY(DECODE_READY), .DECODE_PC(DECODE_PC),
        .DECODE_OPCODE(DECODE_OPCODE), .DECODE_RD(DECODE_RD), .DECODE_RS1(DECODE_RS1),
        .DECODE_RS2(DECODE_RS2), .DECODE_CSR(DECODE_CSR), .DECODE_IMM(DECODE_IMM),
        .DECODE_MAIN_HIT(DECODE_MAIN_HIT), .DECODE_COP_HIT(DECODE_COP_HIT),
        .MAIN_ACCEPT(MAIN_ACCEPT), .MAIN_PC(MAIN_PC), .MAIN_OPCODE(MAIN_OPCODE),
        .MAIN_RD(MAIN_RD), .MAIN_RS1(MAIN_RS1), .MAIN_RS2(MAIN_RS2), .MAIN_CSR(MAIN_CSR),
        .MAIN_IMM(MAIN_IMM), .COP_ACCEPT(COP_ACCEPT), .COP_PC(COP_PC), .COP_RD(COP_RD),
        .COP_RS1(COP_RS1), .COP_RS2(COP_RS2)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t cur_in();
        return {DECODE_PC, DECODE_OPCODE, DECODE_RD, DECODE_RS1, DECODE_RS2,
                DECODE_CSR, DECODE_IMM, DECODE_MAIN_HIT, DECODE_COP_HIT};
    endfunction

    function automatic logic bypass_now();
`ifdef DISPATCH_BYPASS_EN
        return q.size() == 0 && DECODE_VALID && !STALL && !MMU_WAIT && !FLUSH;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_outs();
        ent_t h = '0;
        logic byp = bypass_now();
        logic vis = byp || q.size() != 0;
        if (byp) h = cur_in();
        else if (q.size() != 0) h = q[0];
        chk("decode_ready", DECODE_READY, q.size() != DEPTH);
        chk("main_accept", MAIN_ACCEPT, {1'b0, vis && h.mh});
        chk("cop_accept", COP_ACCEPT, {1'b0, vis && h.ch});
        chk("main_pc", MAIN_PC, {32'b0, h.pc});
        chk("main_opcode", MAIN_OPCODE, {17'b0, vis ? h.op : NOP_OP});
        chk("main_regs", {MAIN_RD, MAIN_RS1, MAIN_RS2}, {5'b0, h.rd, 5'b0, h.rs1, 5'b0, h.rs2});
        chk("main_csr_imm", {MAIN_CSR, MAIN_IMM}, {12'b0, h.csr, 32'b0, h.imm});
        chk("cop_fields", {COP_PC, COP_RD, COP_RS1, COP_RS2},
            {32'b0, h.pc, 5'b0, h.rd, 5'b0, h.rs1, 5'b0, h.rs2});
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic mh, input logic ch,
                         input logic st, input logic mw, input logic fl);
        DECODE_VALID    = v;
        DECODE_PC       = pc;
        DECODE_OPCODE   = 17'($urandom);
        DECODE_RD       = 5'($urandom);
        DECODE_RS1      = 5'($urandom);
        DECODE_RS2      = 5'($urandom);
        DECODE_CSR      = 12'($urandom);
        DECODE_IMM      = $urandom;
        DECODE_MAIN_HIT = mh;
        DECODE_COP_HIT  = ch;
        STALL           = st;
        MMU_WAIT        = mw;
        FLUSH           = fl;
    endtask

    // Check outputs before the edge, then advance the model by one clock.
    task automatic step();
        logic byp, rdy, pp;
        ent_t e;
        #1;
        check_outs();
        byp = bypass_now();
        rdy = q.size() != DEPTH;
        pp  = !STALL && !MMU_WAIT && q.size() != 0;
        e   = cur_in();
        @(posedge CLK);
        if (FLUSH) q.delete();
        else begin
            if (pp) void'(q.pop_front());
            if (DECODE_VALID && rdy && !byp) q.push_back(e);
        end
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        @(negedge CLK);
        check_outs();
        RST = 1'b0;
        // fill under stall: fifth push must be refused
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'(i * 4), 1, 0, 1, 0, 0);
            step();
        end
        #1;
        chk("fill_ready_low", DECODE_READY, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            step();
        end
        #1;
        chk("drained_nop", MAIN_OPCODE, {17'b0, NOP_OP});
        // two entries, then push+pop every cycle across pointer wrap
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'h40 + 32'(i * 4), 1, 0, 1, 0, 0);
            step();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h48 + 32'(i * 4), 1, $urandom_range(0, 1), 0, 0, 0);
            step();
        end
        chk("steady_count", q.size(), 2);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        // flush with count=3 and a valid input in the same cycle
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h80 + 32'(i * 4), 1, 0, 1, 0, 0);
            step();
        end
        drive(1, 32'hDEAD, 1, 0, 1, 0, 1);
        step();
        drive(0, 0, 0, 0, 1, 0, 0);
        #1;
        chk("flush_accept", MAIN_ACCEPT, 2'b00);
        chk("flush_pc", MAIN_PC, 64'h0);
        chk("flush_ready", DECODE_READY, 1'b1);
        step();
        // coprocessor routing held by MMU_WAIT
        drive(1, 32'hC0, 0, 1, 1, 0, 0);
        DECODE_RD = 5'd7;
        step();
        drive(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("cop_route_accept", {COP_ACCEPT, MAIN_ACCEPT}, 4'b0100);
            chk("cop_route_rd", COP_RD, 10'd7);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        // async reset mid-burst with three queued entries
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h300 + 32'(i * 4), 1, 0, 1, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        RST = 1'b1;
        q.delete();
        #1;
        check_outs();
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        drive(1, 32'h100, 1, 0, 1, 0, 0);
        step();
        drive(0, 0, 0, 0, 1, 0, 0);
        #1;
        chk("post_reset_pc", MAIN_PC, {32'b0, 32'h100});
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        // empty queue, adv=1: zero latency with bypass, one cycle without
        drive(1, 32'h200, 1, 0, 0, 0, 0);
        #1;
`ifdef DISPATCH_BYPASS_EN
        chk("bypass_pc", MAIN_PC, {32'b0, 32'h200});
`else
        chk("no_bypass_pc", MAIN_PC, 64'h0);
`endif
        step();
        drive(0, 0, 0, 0, 1, 0, 0);
        #1;
`ifdef DISPATCH_BYPASS_EN
        chk("bypass_count0", DECODE_READY && MAIN_ACCEPT == 2'b00, 1'b1);
`else
        chk("no_bypass_next", MAIN_PC, {32'b0, 32'h200});
`endif
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        // random traffic
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 9) < 3, $urandom_range(0, 19) < 3, $urandom_range(0, 31) == 0);
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
